// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset synchroniser/sequencer.
// State enum, reset-cause encodings, counter/index width functions.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    SYNC,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  localparam logic CAUSE_HW = 1'b0;
  localparam logic CAUSE_SW = 1'b1;

  function automatic int cnt_width(
    input int hold,
    input int gap
  );
    int m;
    m = (hold > gap) ? hold : gap;
    if (m < 1) begin
      return 1;
    end
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_core.sv
// NUM_STAGES-deep reset synchroniser: async assert, sync release.
// Ports: CLK, RST (async active-low), SYNC_OUT (synchronised reset_n).
module rst_sync_core
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_OUT
);

  logic [NUM_STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign SYNC_OUT = chain[NUM_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// Reset synchroniser + hold stretcher + staggered per-channel release.
// Ports: CLK, RST, SW_RST_REQ in; SYNC_RST[NUM_CH], RST_DONE out;
// RST_CAUSE out only when RST_SEQ_CAUSE_EN is defined.
module rst_sync_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic              RST_CAUSE
`endif
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = idx_width(NUM_CH);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);
  localparam logic [IW-1:0] CH_ONE  = IW'(1);

  localparam bit ONE_SHOT = (NUM_CH == 1) || (GAP_CYCLES == 0);

  logic sync_n;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ch_q, ch_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic done_q, done_d;

  logic hold_act;
  logic sw_ok;
  logic [CW-1:0] hold_cnt;

  rst_sync_core #(
    .NUM_STAGES(NUM_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .SYNC_OUT(sync_n)
  );

  // HOLD is entered on the edge where sync_n rises. That edge
  // is only visible one cycle later, so SYNC with sync_n high
  // acts as the first HOLD cycle with a full counter.
  assign hold_act = (state_q == HOLD) ||
                    ((state_q == SYNC) && sync_n);

  assign hold_cnt = (state_q == SYNC) ? HOLD_LD : cnt_q;

  assign sw_ok = SW_RST_REQ &&
                 ((state_q != SYNC) || sync_n);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rst_d   = rst_q;
    done_d  = done_q;
    if (sw_ok) begin
      state_d = HOLD;
      cnt_d   = HOLD_LD;
      ch_d    = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (1'b1)
        hold_act: begin
          if (hold_cnt == CNT_ONE) begin
            if (ONE_SHOT) begin
              rst_d   = '1;
              done_d  = 1'b1;
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              rst_d   = NUM_CH'(1);
              state_d = RELEASE;
              cnt_d   = GAP_LD;
              ch_d    = CH_ONE;
            end
          end else begin
            state_d = HOLD;
            cnt_d   = hold_cnt - 1'b1;
          end
        end
        (state_q == RELEASE): begin
          if (cnt_q == CNT_ONE) begin
            rst_d = rst_q | (NUM_CH'(1) << ch_q);
            if (ch_q == LAST_CH) begin
              done_d  = 1'b1;
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              ch_d  = ch_q + 1'b1;
              cnt_d = GAP_LD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      ch_q    <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign SYNC_RST = rst_q;
  assign RST_DONE = done_q;

`ifdef RST_SEQ_CAUSE_EN
  logic cause_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cause_q <= CAUSE_HW;
    end else if (sw_ok) begin
      cause_q <= CAUSE_SW;
    end
  end

  assign RST_CAUSE = cause_q;
`endif

endmodule

// File: tb/tb_rst_sync_seq.sv
// Scoreboard bench for rst_sync_seq: main config plus
// zero-gap and single-channel corners sharing CLK/RST/SW.
module tb_rst_sync_seq;

  typedef struct {
    longint     t;
    logic [7:0] r;
    logic       d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sw;

  logic [2:0] sr0;
  logic       dn0;
  logic [3:0] sr1;
  logic       dn1;
  logic [0:0] sr2;
  logic       dn2;
`ifdef RST_SEQ_CAUSE_EN
  logic ca0, ca1, ca2;
`endif

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [8:0] p0 = '0, p1 = '0, p2 = '0;
  logic [8:0] c0, c1, c2;
  exp_t e0, e1, e2;

  always #5 clk = ~clk;

  rst_sync_seq #(
    .NUM_STAGES(3), .NUM_CH(3),
    .HOLD_CYCLES(4), .GAP_CYCLES(2)
  ) dut0 (
    .CLK(clk), .RST(rst), .SW_RST_REQ(sw),
    .SYNC_RST(sr0), .RST_DONE(dn0)
`ifdef RST_SEQ_CAUSE_EN
    , .RST_CAUSE(ca0)
`endif
  );

  rst_sync_seq #(
    .NUM_STAGES(2), .NUM_CH(4),
    .HOLD_CYCLES(4), .GAP_CYCLES(0)
  ) dut1 (
    .CLK(clk), .RST(rst), .SW_RST_REQ(sw),
    .SYNC_RST(sr1), .RST_DONE(dn1)
`ifdef RST_SEQ_CAUSE_EN
    , .RST_CAUSE(ca1)
`endif
  );

  rst_sync_seq #(
    .NUM_STAGES(2), .NUM_CH(1),
    .HOLD_CYCLES(4), .GAP_CYCLES(2)
  ) dut2 (
    .CLK(clk), .RST(rst), .SW_RST_REQ(sw),
    .SYNC_RST(sr2), .RST_DONE(dn2)
`ifdef RST_SEQ_CAUSE_EN
    , .RST_CAUSE(ca2)
`endif
  );

  task automatic chk(
    input string  nm,
    input longint act,
    input longint exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ex(
    input longint     t,
    input logic [7:0] r,
    input logic       d
  );
    exp_t e;
    e.t = t;
    e.r = r;
    e.d = d;
    return e;
  endfunction

  // All three DUTs see an output change at the same time
  task automatic push_all(
    input longint t,
    input logic [7:0] r1,
    input logic [7:0] r0,
    input logic d
  );
    q0.push_back(ex(t, r0, d));
    q1.push_back(ex(t, r1, d));
    q2.push_back(ex(t, r0 & 8'h1, d));
  endtask

  always @(negedge clk) begin
    c0 = {5'b0, sr0, dn0};
    if (c0 !== p0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut0 unexpected act=%0h t=%0t",
                 c0, $time);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 val", longint'(c0), longint'({e0.r, e0.d}));
        chk("dut0 time", $time, e0.t);
      end
      p0 = c0;
    end
  end

  always @(negedge clk) begin
    c1 = {4'b0, sr1, dn1};
    if (c1 !== p1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1 unexpected act=%0h t=%0t",
                 c1, $time);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 val", longint'(c1), longint'({e1.r, e1.d}));
        chk("dut1 time", $time, e1.t);
      end
      p1 = c1;
    end
  end

  always @(negedge clk) begin
    c2 = {7'b0, sr2, dn2};
    if (c2 !== p2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut2 unexpected act=%0h t=%0t",
                 c2, $time);
      end else begin
        e2 = q2.pop_front();
        chk("dut2 val", longint'(c2), longint'({e2.r, e2.d}));
        chk("dut2 time", $time, e2.t);
      end
      p2 = c2;
    end
  end

  initial begin
    rst = 1'b0;
    sw  = 1'b0;
    #2;
    chk("por sr0", sr0, 0);
    chk("por dn0", dn0, 0);
    chk("por sr1", sr1, 0);

    // power-up release at t=13
    #11;
    q0.push_back(ex(80, 8'h1, 1'b0));
    q0.push_back(ex(100, 8'h3, 1'b0));
    q0.push_back(ex(120, 8'h7, 1'b1));
    q1.push_back(ex(70, 8'hf, 1'b1));
    q2.push_back(ex(70, 8'h1, 1'b1));
    rst = 1'b1;
    #61;
    chk("hold sr0 t74", sr0, 0);
    chk("hold dn0 t74", dn0, 0);
    #48;
    chk("run sr0", sr0, 3'h7);
    chk("run dn0", dn0, 1);
    chk("run sr1", sr1, 4'hf);
    chk("run sr2", sr2, 1);
`ifdef RST_SEQ_CAUSE_EN
    chk("cause hw", ca0, 0);
`endif

    // board reset pulse, then abort mid-release
    #6;
    push_all(130, 8'h0, 8'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk("async sr0", sr0, 0);
    chk("async dn0", dn0, 0);
    #4;
    q0.push_back(ex(200, 8'h1, 1'b0));
    q1.push_back(ex(190, 8'hf, 1'b1));
    q2.push_back(ex(190, 8'h1, 1'b1));
    rst = 1'b1;
    #75;
    push_all(210, 8'h0, 8'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort sr0", sr0, 0);
    chk("abort sr1", sr1, 0);
    #14;
    q0.push_back(ex(290, 8'h1, 1'b0));
    q0.push_back(ex(310, 8'h3, 1'b0));
    q0.push_back(ex(330, 8'h7, 1'b1));
    q1.push_back(ex(280, 8'hf, 1'b1));
    q2.push_back(ex(280, 8'h1, 1'b1));
    rst = 1'b1;

    // single-cycle software request at edge 345
    #117;
    push_all(350, 8'h0, 8'h0, 1'b0);
    q0.push_back(ex(390, 8'h1, 1'b0));
    q0.push_back(ex(410, 8'h3, 1'b0));
    q0.push_back(ex(430, 8'h7, 1'b1));
    q1.push_back(ex(390, 8'hf, 1'b1));
    q2.push_back(ex(390, 8'h1, 1'b1));
    sw = 1'b1;
    #10;
    sw = 1'b0;
    #10;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause sw", ca0, 1);
    chk("cause sw ch1", ca1, 1);
`endif
    #72;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause hold", ca0, 1);
`endif
    chk("sw run sr0", sr0, 3'h7);

    // held request over edges 445..475
    #8;
    push_all(450, 8'h0, 8'h0, 1'b0);
    q0.push_back(ex(520, 8'h1, 1'b0));
    q1.push_back(ex(520, 8'hf, 1'b1));
    q2.push_back(ex(520, 8'h1, 1'b1));
    sw = 1'b1;
    #40;
    sw = 1'b0;

    // request while releasing, edge 525
    #40;
    push_all(530, 8'h0, 8'h0, 1'b0);
    q0.push_back(ex(570, 8'h1, 1'b0));
    q0.push_back(ex(590, 8'h3, 1'b0));
    q0.push_back(ex(610, 8'h7, 1'b1));
    q1.push_back(ex(570, 8'hf, 1'b1));
    q2.push_back(ex(570, 8'h1, 1'b1));
    sw = 1'b1;
    #10;
    sw = 1'b0;

    // request during SYNC must be ignored
    #98;
    push_all(630, 8'h0, 8'h0, 1'b0);
    rst = 1'b0;
    #1;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause clr", ca0, 0);
`endif
    chk("rst2 dn0", dn0, 0);
    #1;
    sw = 1'b1;
    #3;
    q0.push_back(ex(700, 8'h1, 1'b0));
    q0.push_back(ex(720, 8'h3, 1'b0));
    q0.push_back(ex(740, 8'h7, 1'b1));
    q1.push_back(ex(690, 8'hf, 1'b1));
    q2.push_back(ex(690, 8'h1, 1'b1));
    rst = 1'b1;
    #17;
    sw = 1'b0;
    #95;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause sync", ca0, 0);
`endif
    chk("end sr0", sr0, 3'h7);
    chk("end dn2", dn2, 1);
    #15;
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
